// File: rtl/data_sram_responder.sv
// data_sram_responder: in-order SRAM-like data responder with a fixed-latency word memory.
// Ports: clk/reset, data_sram_{req,wr,size,wstrb,addr,wdata}, resp_stall -> addr_ok, data_ok, rdata.
module data_sram_responder #(
    parameter int OUTSTANDING = 2,
    parameter int LAT         = 2,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        resp_stall,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef struct packed {
        logic          wr;
        logic [1:0]    size;
        logic [3:0]    wstrb;
        logic [IW-1:0] idx;
        logic [31:0]   wdata;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    entry_t        q_mem [OUTSTANDING];
    logic [31:0]   mem   [MEM_WORDS];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          data_ok_q;
    logic [31:0]   rdata_q;

    logic          push, pop;
    entry_t        new_e, head_e;
    logic          unused_size_addr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Acceptance looks only at the registered count: no pop bypass.
    assign data_sram_addr_ok = data_sram_req & (count_q < CW'(OUTSTANDING)) & ~resp_stall;
    assign push              = data_sram_req & data_sram_addr_ok;

    assign new_e.wr    = data_sram_wr;
    assign new_e.size  = data_sram_size;
    assign new_e.wstrb = data_sram_wstrb;
    assign new_e.idx   = data_sram_addr[IW+1:2];
    assign new_e.wdata = data_sram_wdata;
    assign head_e      = q_mem[head_q];

    // Size is only recorded; upper address bits alias away.
    assign unused_size_addr = ^{head_e.size, data_sram_addr[31:IW+2], data_sram_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A push into an empty queue starts its latency at the same edge.
                if (count_q != '0 || push) begin
                    state_d = BUSY;
                    cnt_d   = LW'(LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    pop = 1'b1;
                    if (count_q > CW'(1) || push) begin
                        cnt_d = LW'(LAT - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = pop  ? ptr_next(head_q) : head_q;
        tail_d  = push ? ptr_next(tail_q) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            data_ok_q <= pop;
            if (pop) begin
                rdata_q <= head_e.wr ? 32'h0 : mem[head_e.idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail_q] <= new_e;
        end
    end

    // Writes commit only when they reach completion, in queue order.
    always_ff @(posedge clk) begin
        if (pop && head_e.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (head_e.wstrb[i]) begin
                    mem[head_e.idx][8*i +: 8] <= head_e.wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed table plus hand sequences for data_sram_responder.
// Default parameters: OUTSTANDING=2, LAT=2, MEM_WORDS=1024.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        resp_stall;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    data_sram_responder dut (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .resp_stall        (resp_stall),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        s_aok;
    logic        s_dok;
    logic [31:0] s_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called 1ns after a rising edge; samples at the falling edge.
    task automatic cyc(input logic rq, input logic wr, input logic [3:0] st,
                       input logic [31:0] ad, input logic [31:0] wd, input logic stl);
        data_sram_req   = rq;
        data_sram_wr    = wr;
        data_sram_size  = 2'd2;
        data_sram_wstrb = st;
        data_sram_addr  = ad;
        data_sram_wdata = wd;
        resp_stall      = stl;
        @(negedge clk);
        s_aok = data_sram_addr_ok;
        s_dok = data_sram_data_ok;
        s_rd  = data_sram_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic void add(input logic rq, input logic wr, input logic [3:0] st,
                                input logic [31:0] ad, input logic [31:0] wd,
                                input logic aok, input logic dok,
                                input logic ck, input logic [31:0] rd);
        vec_t v;
        v.req = rq; v.wr = wr; v.strb = st; v.addr = ad; v.wdata = wd;
        v.aok = aok; v.dok = dok; v.chk = ck; v.rd = rd;
        tbl.push_back(v);
    endfunction

    function automatic void add_idle(input logic dok, input logic ck, input logic [31:0] rd);
        add(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, dok, ck, rd);
    endfunction

    initial begin
        reset = 1'b1;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        resp_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset data_ok", {31'h0, data_sram_data_ok}, 32'h0);
        chk("reset rdata", data_sram_rdata, 32'h0);

        // Read latency: preload mem[4], read it back.
        add(1, 1, 4'hF, 32'h10, 32'h11223344, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0);
        add_idle(1, 1, 32'h0);
        add(1, 0, 4'hF, 32'h10, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0);
        add_idle(1, 1, 32'h11223344);
        // Byte strobes over a cleared word.
        add(1, 1, 4'hF, 32'h20, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0); add_idle(1, 0, 0);
        add(1, 1, 4'h5, 32'h20, 32'hAABBCCDD, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0); add_idle(1, 0, 0);
        add(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0);
        add_idle(1, 1, 32'h00BB00DD);
        // Address wrap: 0x1004 aliases to word 1.
        add(1, 1, 4'hF, 32'h1004, 32'h1, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0); add_idle(1, 0, 0);
        add(1, 0, 4'hF, 32'h4, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0);
        add_idle(1, 1, 32'h1);
        // Zero strobe write completes but changes nothing.
        add(1, 1, 4'h0, 32'h4, 32'hFFFFFFFF, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0); add_idle(1, 0, 0);
        add(1, 0, 4'hF, 32'h4, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0); add_idle(0, 0, 0);
        add_idle(1, 1, 32'h1);
        // Write then read of the same word queued back to back.
        add(1, 1, 4'hF, 32'h30, 32'h12345678, 1, 0, 0, 0);
        add(1, 0, 4'hF, 32'h30, 32'h0, 1, 0, 0, 0);
        add_idle(0, 0, 0);
        add_idle(1, 1, 32'h0);
        add_idle(0, 0, 0);
        add_idle(1, 1, 32'h12345678);
        add_idle(0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].req, tbl[i].wr, tbl[i].strb, tbl[i].addr, tbl[i].wdata, 1'b0);
            chk($sformatf("vec%0d addr_ok", i), {31'h0, s_aok}, {31'h0, tbl[i].aok});
            chk($sformatf("vec%0d data_ok", i), {31'h0, s_dok}, {31'h0, tbl[i].dok});
            if (tbl[i].chk) chk($sformatf("vec%0d rdata", i), s_rd, tbl[i].rd);
        end

        // Back-pressure with a full queue.
        cyc(1, 0, 4'hF, 32'h10, 32'h0, 0);
        chk("bp c0 addr_ok", {31'h0, s_aok}, 32'h1);
        cyc(1, 0, 4'hF, 32'h20, 32'h0, 0);
        chk("bp c1 addr_ok", {31'h0, s_aok}, 32'h1);
        cyc(1, 0, 4'hF, 32'h30, 32'h0, 0);
        chk("bp c2 addr_ok", {31'h0, s_aok}, 32'h0);
        chk("bp c2 data_ok", {31'h0, s_dok}, 32'h0);
        cyc(1, 0, 4'hF, 32'h30, 32'h0, 0);
        chk("bp c3 addr_ok", {31'h0, s_aok}, 32'h1);
        chk("bp c3 data_ok", {31'h0, s_dok}, 32'h1);
        chk("bp c3 rdata", s_rd, 32'h11223344);
        idle(); chk("bp c4 data_ok", {31'h0, s_dok}, 32'h0);
        idle(); chk("bp c5 data_ok", {31'h0, s_dok}, 32'h1);
        chk("bp c5 rdata", s_rd, 32'h00BB00DD);
        idle(); chk("bp c6 data_ok", {31'h0, s_dok}, 32'h0);
        idle(); chk("bp c7 data_ok", {31'h0, s_dok}, 32'h1);
        chk("bp c7 rdata", s_rd, 32'h12345678);
        idle(); chk("bp c8 data_ok", {31'h0, s_dok}, 32'h0);

        // Stall holds addr_ok low and nothing enters the queue.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 4'hF, 32'h10, 32'h0, 1);
            chk($sformatf("stall%0d addr_ok", i), {31'h0, s_aok}, 32'h0);
            chk($sformatf("stall%0d data_ok", i), {31'h0, s_dok}, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            idle(); chk($sformatf("post-stall%0d data_ok", i), {31'h0, s_dok}, 32'h0);
        end
        cyc(1, 0, 4'hF, 32'h10, 32'h0, 0);
        chk("post-stall read addr_ok", {31'h0, s_aok}, 32'h1);
        idle(); chk("post-stall r1 data_ok", {31'h0, s_dok}, 32'h0);
        idle(); chk("post-stall r2 data_ok", {31'h0, s_dok}, 32'h0);
        idle(); chk("post-stall r3 data_ok", {31'h0, s_dok}, 32'h1);
        chk("post-stall rdata", s_rd, 32'h11223344);

        // Reset discards an uncommitted write.
        cyc(1, 1, 4'hF, 32'h40, 32'h0BADF00D, 0);
        chk("pre40 addr_ok", {31'h0, s_aok}, 32'h1);
        idle(); idle(); idle();
        chk("pre40 data_ok", {31'h0, s_dok}, 32'h1);
        cyc(1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0);
        chk("rst-wr addr_ok", {31'h0, s_aok}, 32'h1);
        data_sram_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst-wr data_ok", {31'h0, data_sram_data_ok}, 32'h0);
        data_sram_req = 1'b1; data_sram_wr = 1'b0;
        #1;
        chk("rst-wr count0 addr_ok", {31'h0, data_sram_addr_ok}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        data_sram_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(); chk($sformatf("rst-wr idle%0d data_ok", i), {31'h0, s_dok}, 32'h0);
        end
        cyc(1, 0, 4'hF, 32'h40, 32'h0, 0);
        chk("rd40 addr_ok", {31'h0, s_aok}, 32'h1);
        idle(); idle(); idle();
        chk("rd40 data_ok", {31'h0, s_dok}, 32'h1);
        chk("rd40 rdata", s_rd, 32'h0BADF00D);

        // Reset during a data_ok cycle drops it at once.
        cyc(1, 0, 4'hF, 32'h10, 32'h0, 0);
        idle(); idle();
        chk("rst-dok before", {31'h0, data_sram_data_ok}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst-dok after", {31'h0, data_sram_data_ok}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(); chk("rst-dok idle0 data_ok", {31'h0, s_dok}, 32'h0);
        idle(); chk("rst-dok idle1 data_ok", {31'h0, s_dok}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
